// File: rtl/dma_pkg.sv
// dma_pkg: shared definitions for the DMA transfer sequencer.
//   dma_state_e : sequencer state encoding (3 bits)
//   DMA_WIDTH   : default address/data width
//   DMA_LEN_W   : default width of the length field and transfer counter
package dma_pkg;

  localparam int DMA_WIDTH = 8;
  localparam int DMA_LEN_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_DONE    = 3'd4
  } dma_state_e;

endpackage

// File: rtl/dma_xfer_ctrl.sv
// dma_xfer_ctrl: executes one memory-to-memory copy per accepted start pulse.
// Each word is moved as read request -> read return -> write request.
//
// Ports:
//   clk, arst_n         clock (rising edge); asynchronous reset, active HIGH
//   start               one-cycle start pulse, only accepted in IDLE
//   src_addr, dst_addr  first read / first write address, latched on start
//   data_len            number of words to copy, latched on start (0 = no-op)
//   rd_req/rd_addr      read request and address to memory
//   rd_gnt              read accepted this cycle
//   rd_valid/rd_data    read return (only looked at while waiting for data)
//   wr_req/wr_addr/wr_data  write request, address and data to memory
//   wr_gnt              write accepted this cycle
//   busy                high from the cycle after start through the done cycle
//   done                one-cycle completion pulse
//   xfer_cnt            words written in the current or last transfer
//
// Handshake: a request (rd_req / wr_req) rises and stays high, with its
// address/data held constant, until the matching grant is seen high at a
// rising clock edge; the request drops in the following cycle. A grant while
// the request is low has no effect.
module dma_xfer_ctrl
  import dma_pkg::*;
#(
  parameter int WIDTH = DMA_WIDTH,
  parameter int LEN_W = DMA_LEN_W
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] src_addr,
  input  logic [WIDTH-1:0] dst_addr,
  input  logic [LEN_W-1:0] data_len,
  output logic             rd_req,
  output logic [WIDTH-1:0] rd_addr,
  input  logic             rd_gnt,
  input  logic             rd_valid,
  input  logic [WIDTH-1:0] rd_data,
  output logic             wr_req,
  output logic [WIDTH-1:0] wr_addr,
  output logic [WIDTH-1:0] wr_data,
  input  logic             wr_gnt,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] xfer_cnt
);

  dma_state_e       state_q, state_d;
  logic [WIDTH-1:0] src_q, dst_q, data_q;
  logic [LEN_W-1:0] rem_q, cnt_q;
  logic             rd_req_q, wr_req_q, busy_q, done_q;

  logic accept, rd_take, wr_take;

  assign accept  = (state_q == ST_IDLE)    && start;
  assign rd_take = (state_q == ST_RD_WAIT) && rd_valid;
  assign wr_take = (state_q == ST_WR_REQ)  && wr_gnt;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (data_len == '0) ? ST_DONE : ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        if (rd_gnt) state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (rd_valid) state_d = ST_WR_REQ;
      end
      ST_WR_REQ: begin
        // rem_q still counts the word being written, so 1 means last word.
        if (wr_gnt) state_d = (rem_q == LEN_W'(1)) ? ST_DONE : ST_RD_REQ;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, registered status outputs and datapath. Status flops are loaded
  // from the next state so they line up exactly with state_q.
  always_ff @(posedge clk or posedge arst_n) begin
    if (arst_n) begin
      state_q  <= ST_IDLE;
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      src_q    <= '0;
      dst_q    <= '0;
      data_q   <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rd_req_q <= (state_d == ST_RD_REQ);
      wr_req_q <= (state_d == ST_WR_REQ);
      busy_q   <= (state_d != ST_IDLE);
      done_q   <= (state_d == ST_DONE);

      if (accept) begin
        src_q <= src_addr;
        dst_q <= dst_addr;
        rem_q <= data_len;
        cnt_q <= '0;
      end

      if (rd_take) begin
        data_q <= rd_data;
      end

      // Address increments wrap naturally at 2^WIDTH.
      if (wr_take) begin
        src_q <= src_q + WIDTH'(1);
        dst_q <= dst_q + WIDTH'(1);
        rem_q <= rem_q - LEN_W'(1);
        cnt_q <= cnt_q + LEN_W'(1);
      end
    end
  end

  assign rd_req   = rd_req_q;
  assign wr_req   = wr_req_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_addr  = src_q;
  assign wr_addr  = dst_q;
  assign wr_data  = data_q;
  assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_dma_xfer_ctrl.sv
// tb_dma_xfer_ctrl: directed + randomized bench for dma_xfer_ctrl.
// A memory responder with configurable grant/return delays serves the DUT;
// the expected read/write sequences come from the copy rule itself
// (word i reads src+i and writes mem[src+i] to dst+i, modulo 256).
module tb_dma_xfer_ctrl;
  import dma_pkg::*;

  localparam int W  = 8;
  localparam int LW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  logic          start;
  logic [W-1:0]  src_addr, dst_addr;
  logic [LW-1:0] data_len;
  logic          rd_req, rd_gnt, rd_valid;
  logic [W-1:0]  rd_addr, rd_data;
  logic          wr_req, wr_gnt;
  logic [W-1:0]  wr_addr, wr_data;
  logic          busy, done;
  logic [LW-1:0] xfer_cnt;

  dma_xfer_ctrl #(.WIDTH(W), .LEN_W(LW)) dut (
    .clk(clk), .arst_n(arst_n), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .data_len(data_len),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .busy(busy), .done(done), .xfer_cnt(xfer_cnt)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;

  logic [W-1:0]   mem [256];
  logic [W-1:0]   exp_rd_q [$];
  logic [2*W-1:0] exp_q    [$];   // {wr_addr, wr_data}
  logic [W-1:0]   obs_rd_q [$];
  logic [2*W-1:0] obs_wr_q [$];

  int cfg_rd_dly = 0;
  int cfg_rd_lat = 1;
  int cfg_wr_dly = 0;
  bit cfg_noise  = 1'b0;
  int done_pulses = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (done === 1'b1) done_pulses++;

  // ---------------- memory responder ----------------
  initial begin
    int rd_cnt, wr_cnt, vcd;
    logic [W-1:0] paddr, hold_ra, hold_wa, hold_wd;
    bit rd_held, wr_held;
    rd_cnt = 0; wr_cnt = 0; vcd = 0; rd_held = 0; wr_held = 0;
    paddr = '0; hold_ra = '0; hold_wa = '0; hold_wd = '0;
    rd_gnt = 0; rd_valid = 0; rd_data = '0; wr_gnt = 0;
    forever begin
      @(negedge clk);
      rd_gnt = 0; rd_valid = 0; wr_gnt = 0;
      if (arst_n !== 1'b0) begin
        rd_cnt = 0; wr_cnt = 0; vcd = 0; rd_held = 0; wr_held = 0;
      end else begin
        if (vcd > 0) begin
          vcd--;
          if (vcd == 0) begin rd_valid = 1; rd_data = mem[paddr]; end
        end
        if (rd_req) begin
          if (rd_held) check("rd_addr_stable", rd_addr, hold_ra);
          hold_ra = rd_addr; rd_held = 1;
          if (rd_cnt >= cfg_rd_dly) begin
            rd_gnt = 1; obs_rd_q.push_back(rd_addr);
            paddr = rd_addr; vcd = cfg_rd_lat; rd_cnt = 0; rd_held = 0;
          end else begin
            rd_cnt++;
            // stray read data while still requesting must be ignored
            if (cfg_noise && !rd_valid && $urandom_range(0, 1) == 1) begin
              rd_valid = 1; rd_data = W'($urandom);
            end
          end
        end else if (cfg_noise) begin
          rd_gnt = 1'($urandom_range(0, 1));
        end
        if (wr_req) begin
          if (wr_held) begin
            check("wr_addr_stable", wr_addr, hold_wa);
            check("wr_data_stable", wr_data, hold_wd);
          end
          hold_wa = wr_addr; hold_wd = wr_data; wr_held = 1;
          if (wr_cnt >= cfg_wr_dly) begin
            wr_gnt = 1; obs_wr_q.push_back({wr_addr, wr_data});
            wr_cnt = 0; wr_held = 0;
          end else begin
            wr_cnt++;
          end
        end else if (cfg_noise) begin
          wr_gnt = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // ---------------- driver / checker ----------------
  task automatic run_xfer(input logic [W-1:0] s, input logic [W-1:0] d, input int n,
                          input int rdd, input int rdl, input int wrd, input bit noise,
                          input bit timed, input int ign_at, input bit start_at_done);
    int cyc, p0;
    bit got;
    logic [W-1:0] ra;
    exp_rd_q.delete(); exp_q.delete(); obs_rd_q.delete(); obs_wr_q.delete();
    for (int i = 0; i < n; i++) begin
      ra = s + W'(i);
      exp_rd_q.push_back(ra);
      exp_q.push_back({W'(d + W'(i)), mem[ra]});
    end
    cfg_rd_dly = rdd; cfg_rd_lat = rdl; cfg_wr_dly = wrd; cfg_noise = noise;
    @(negedge clk);
    p0 = done_pulses;
    start = 1; src_addr = s; dst_addr = d; data_len = LW'(n);
    cyc = 0; got = 0;
    while (!got && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      // scramble inputs: the latched copy must not follow them
      src_addr = W'($urandom); dst_addr = W'($urandom); data_len = LW'($urandom_range(1, 9));
      start = (cyc == ign_at);
      if (done === 1'b1) got = 1;
      else check("busy_during", busy, 1);
    end
    check("done_seen", got, 1);
    if (timed) check("done_cycle", cyc, 3 * n + 1);
    check("busy_at_done", busy, 1);
    check("xfer_cnt_done", xfer_cnt, n);
    start = start_at_done;   // sampled on the DONE->IDLE edge: must be ignored
    @(negedge clk);
    start = 0;
    check("busy_after", busy, 0);
    check("done_after", done, 0);
    check("rd_req_after", rd_req, 0);
    check("done_pulses", done_pulses - p0, 1);
    check("xfer_cnt_hold", xfer_cnt, n);
    check("rd_count", obs_rd_q.size(), n);
    check("wr_count", obs_wr_q.size(), n);
    for (int i = 0; i < n && i < obs_rd_q.size(); i++) check("rd_addr_seq", obs_rd_q[i], exp_rd_q[i]);
    for (int i = 0; i < n && i < obs_wr_q.size(); i++) check("wr_seq", obs_wr_q[i], exp_q[i]);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_req"},   rd_req,   0);
    check({tag, "_wr_req"},   wr_req,   0);
    check({tag, "_rd_addr"},  rd_addr,  0);
    check({tag, "_wr_addr"},  wr_addr,  0);
    check({tag, "_wr_data"},  wr_data,  0);
    check({tag, "_busy"},     busy,     0);
    check({tag, "_done"},     done,     0);
    check({tag, "_xfer_cnt"}, xfer_cnt, 0);
  endtask

  initial begin
    int cyc, p0;
    for (int i = 0; i < 256; i++) mem[i] = W'($urandom);
    arst_n = 1; start = 0; src_addr = '0; dst_addr = '0; data_len = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    arst_n = 0;
    @(negedge clk);

    // single word, zero-wait
    run_xfer(8'h10, 8'h80, 1, 0, 1, 0, 0, 1, 0, 0);
    // burst of three, zero-wait
    run_xfer(8'h20, 8'h40, 3, 0, 1, 0, 0, 1, 0, 0);
    // zero length, plus a start on the DONE->IDLE edge
    run_xfer(8'h55, 8'h66, 0, 0, 1, 0, 0, 1, 0, 1);
    // wait states with stray grants/data
    run_xfer(8'h33, 8'h90, 3, 3, 2, 4, 1, 0, 0, 0);
    // address wrap with an ignored mid-transfer start
    run_xfer(8'hFE, 8'h70, 4, 0, 1, 0, 0, 1, 5, 0);

    // reset while a write is pending
    cfg_rd_dly = 0; cfg_rd_lat = 1; cfg_wr_dly = 20; cfg_noise = 0;
    @(negedge clk);
    start = 1; src_addr = 8'hA0; dst_addr = 8'hB0; data_len = 8'd3;
    cyc = 0;
    do begin
      @(negedge clk);
      start = 0;
      cyc++;
    end while (wr_req !== 1'b1 && cyc < 100);
    check("wr_req_reached", wr_req, 1);
    p0 = done_pulses;
    #2 arst_n = 1;
    #1 check_all_zero("midreset");
    repeat (2) @(negedge clk);
    check("midreset_busy", busy, 0);
    arst_n = 0;
    repeat (2) @(negedge clk);
    check("midreset_no_done", done_pulses - p0, 0);
    run_xfer(8'h05, 8'h06, 2, 0, 1, 0, 0, 1, 0, 0);

    // randomized transfers
    for (int k = 0; k < 5; k++) begin
      run_xfer(W'($urandom), W'($urandom), $urandom_range(1, 6),
               $urandom_range(0, 3), $urandom_range(1, 3), $urandom_range(0, 3),
               1, 0, $urandom_range(2, 6), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
